// File: rtl/rx_buffered_if.sv
// Packet type for the scheduled optical link and the rx port bundle.
// rx_buffered_pkg carries the fabric packet payload shared by the tx and rx nodes.
package rx_buffered_pkg;
  localparam int unsigned PORTS  = 4;
  localparam int unsigned DEST_W = $clog2(PORTS);
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } packet_t;
endpackage

// Bus between the fabric/sink side (master) and the rx buffer (slave).
interface rx_buffered_if #(
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  rx_buffered_pkg::packet_t din;
  rx_buffered_pkg::packet_t dout;
  logic                     ack;
  logic                     stop;
  logic                     drop;
  logic                     misroute;
  logic [OCC_W-1:0]         occupancy;
  logic [15:0]              rx_cnt;
  logic [15:0]              drop_cnt;
  logic [15:0]              misroute_cnt;

  modport slave (
    input  din, ack,
    output dout, stop, drop, misroute, occupancy, rx_cnt, drop_cnt, misroute_cnt
  );

  modport master (
    output din, ack,
    input  dout, stop, drop, misroute, occupancy, rx_cnt, drop_cnt, misroute_cnt
  );
endinterface

// File: rtl/rx_buffered.sv
// Receive buffer for one output port of the optical scheduled link.
// Filters fabric packets on destination, queues them in a circular FIFO, drains
// them to the sink on valid/ack and raises a hysteretic stop toward the scheduler.
// Optional build macro: RX_STATS_EN enables the saturating event counters.
module rx_buffered
  import rx_buffered_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned STOP_THRESH = 6,
  parameter int unsigned GO_THRESH   = 2,
  parameter int unsigned PORT_ID     = 0
) (
  input  logic           clk,
  input  logic           rst,
  rx_buffered_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic {
    S_GO,
    S_STOP
  } state_t;

  packet_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             dest_match;
  logic             full;
  logic             empty;
  logic             wr;
  logic             rd;
  logic             drop_ev;
  logic             misroute_ev;
  logic             drop_q;
  logic             misroute_q;
  state_t           state;
  state_t           state_next;
  packet_t          head;

  // Accept/read/discard decisions for this cycle and the resulting occupancy.
  always_comb begin
    dest_match  = (bus.din.dest == DEST_W'(PORT_ID));
    full        = (occ == OCC_W'(DEPTH));
    empty       = (occ == '0);
    rd          = bus.ack && !empty;
    // A read on a full buffer frees the slot on the same edge, so the write still fits.
    wr          = bus.din.valid && dest_match && (!full || rd);
    drop_ev     = bus.din.valid && dest_match && full && !rd;
    misroute_ev = bus.din.valid && !dest_match;
    occ_next    = occ + OCC_W'(wr) - OCC_W'(rd);
  end

  // Pointers, occupancy and the one-cycle event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      drop_q     <= 1'b0;
      misroute_q <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      occ        <= occ_next;
      drop_q     <= drop_ev;
      misroute_q <= misroute_ev;
    end
  end

  // Packet storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.din;
  end

  // Stop FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_GO;
    else      state <= state_next;
  end

  // Stop FSM next state, judged on post-update occupancy so stop reacts in one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_GO:    if (occ_next >= OCC_W'(STOP_THRESH)) state_next = S_STOP;
      S_STOP:  if (occ_next <= OCC_W'(GO_THRESH))   state_next = S_GO;
      default: state_next = S_GO;
    endcase
  end

  // Head of FIFO; valid follows occupancy so it drops with reset asynchronously.
  always_comb begin
    head       = mem[rd_ptr];
    head.valid = !empty;
  end

  assign bus.dout      = head;
  assign bus.stop      = (state == S_STOP);
  assign bus.drop      = drop_q;
  assign bus.misroute  = misroute_q;
  assign bus.occupancy = occ;

`ifdef RX_STATS_EN
  logic [15:0] rx_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] misroute_cnt;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt       <= '0;
      drop_cnt     <= '0;
      misroute_cnt <= '0;
    end else begin
      if (wr && (rx_cnt != 16'hFFFF))                rx_cnt       <= rx_cnt + 16'd1;
      if (drop_ev && (drop_cnt != 16'hFFFF))         drop_cnt     <= drop_cnt + 16'd1;
      if (misroute_ev && (misroute_cnt != 16'hFFFF)) misroute_cnt <= misroute_cnt + 16'd1;
    end
  end

  assign bus.rx_cnt       = rx_cnt;
  assign bus.drop_cnt     = drop_cnt;
  assign bus.misroute_cnt = misroute_cnt;
`else
  assign bus.rx_cnt       = 16'h0;
  assign bus.drop_cnt     = 16'h0;
  assign bus.misroute_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_rx_buffered.sv
// Bench for rx_buffered: hand-derived vector table plus a queue scoreboard model.
module tb_rx_buffered;
  import rx_buffered_pkg::*;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned STOP_THRESH = 6;
  localparam int unsigned GO_THRESH   = 2;
  localparam int unsigned PORT_ID     = 0;
  localparam int          NVEC        = 25;

  typedef struct {
    logic        v;
    logic [1:0]  dest;
    logic [31:0] data;
    logic        ack;
    int          occ;
    logic        drop;
    logic        mis;
    logic        stop;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  rx_buffered_if #(.DEPTH(DEPTH)) bus ();

  rx_buffered #(
    .DEPTH      (DEPTH),
    .STOP_THRESH(STOP_THRESH),
    .GO_THRESH  (GO_THRESH),
    .PORT_ID    (PORT_ID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];
  logic        m_stop;
  logic        m_drop;
  logic        m_mis;
  int          m_rx;
  int          m_drops;
  int          m_miss;
  vec_t        tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_stop  = 1'b0;
    m_drop  = 1'b0;
    m_mis   = 1'b0;
    m_rx    = 0;
    m_drops = 0;
    m_miss  = 0;
  endtask

  task automatic check_cnt(input string tag);
`ifdef RX_STATS_EN
    check({tag, "_rx_cnt"},   32'(bus.rx_cnt),       32'(m_rx    > 65535 ? 65535 : m_rx));
    check({tag, "_drop_cnt"}, 32'(bus.drop_cnt),     32'(m_drops > 65535 ? 65535 : m_drops));
    check({tag, "_mis_cnt"},  32'(bus.misroute_cnt), 32'(m_miss  > 65535 ? 65535 : m_miss));
`else
    check({tag, "_rx_cnt"},   32'(bus.rx_cnt),       32'h0);
    check({tag, "_drop_cnt"}, 32'(bus.drop_cnt),     32'h0);
    check({tag, "_mis_cnt"},  32'(bus.misroute_cnt), 32'h0);
`endif
  endtask

  // One clock of stimulus: score the consumed head, predict, clock, compare.
  task automatic step(input logic v, input logic [1:0] d, input logic [31:0] data, input logic a);
    int   sz;
    logic match;
    logic rdm;
    logic wrm;
    sz             = sb.size();
    bus.din.valid  = v;
    bus.din.dest   = d;
    bus.din.data   = data;
    bus.ack        = a;
    match          = (32'(d) == PORT_ID);
    rdm            = a && (sz != 0);
    wrm            = v && match && ((sz < int'(DEPTH)) || rdm);
    m_drop         = v && match && (sz == int'(DEPTH)) && !rdm;
    m_mis          = v && !match;
    if (rdm) begin
      check("head_data", bus.dout.data, sb[0]);
      void'(sb.pop_front());
    end
    if (wrm) begin
      sb.push_back(data);
      m_rx++;
    end
    if (m_drop) m_drops++;
    if (m_mis)  m_miss++;
    if (!m_stop && (sb.size() >= int'(STOP_THRESH)))    m_stop = 1'b1;
    else if (m_stop && (sb.size() <= int'(GO_THRESH))) m_stop = 1'b0;
    @(posedge clk);
    #1;
    check("occupancy",  32'(bus.occupancy),  32'(sb.size()));
    check("dout_valid", 32'(bus.dout.valid), 32'(sb.size() != 0));
    check("drop",       32'(bus.drop),       32'(m_drop));
    check("misroute",   32'(bus.misroute),   32'(m_mis));
    check("stop",       32'(bus.stop),       32'(m_stop));
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      if (sb.size() != 0) step(1'b0, 2'd0, 32'h0, 1'b1);
    end
    check("drained_occ", 32'(bus.occupancy), 32'h0);
  endtask

  initial begin
    // v, dest, data, ack, occ, drop, mis, stop -- expected values after the edge
    tbl[0]  = '{1'b1, 2'd0, 32'hA001, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd3, 32'hBAD0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 2'd3, 32'hBAD1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 32'hA002, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 32'h0,    1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 32'h0,    1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 32'hA003, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 32'hA004, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 32'hA005, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 32'hA006, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'd0, 32'hA007, 1'b0, 5, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 32'hA008, 1'b0, 6, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 2'd0, 32'hA009, 1'b0, 7, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 2'd0, 32'hA00A, 1'b0, 8, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 2'd0, 32'hDEAD, 1'b0, 8, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 2'd0, 32'hA00B, 1'b1, 8, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 2'd2, 32'hBAD2, 1'b0, 8, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 2'd0, 32'h0,    1'b1, 7, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 2'd0, 32'h0,    1'b1, 6, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 2'd0, 32'h0,    1'b1, 5, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 2'd0, 32'h0,    1'b1, 4, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 2'd0, 32'h0,    1'b1, 3, 1'b0, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 2'd0, 32'h0,    1'b1, 2, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 2'd0, 32'h0,    1'b1, 1, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 2'd0, 32'h0,    1'b1, 0, 1'b0, 1'b0, 1'b0};

    model_reset();
    bus.din = '0;
    bus.ack = 1'b0;
    rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_occ",   32'(bus.occupancy),  32'h0);
    check("rst_valid", 32'(bus.dout.valid), 32'h0);
    check("rst_stop",  32'(bus.stop),       32'h0);
    check("rst_drop",  32'(bus.drop),       32'h0);
    check("rst_mis",   32'(bus.misroute),   32'h0);
    check_cnt("rst");
    rst = 1'b1;

    // Vector table: misroute, ack-when-empty, full accept, overflow, hysteresis.
    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].v, tbl[i].dest, tbl[i].data, tbl[i].ack);
      check($sformatf("tbl%0d_occ", i),  32'(bus.occupancy), 32'(tbl[i].occ));
      check($sformatf("tbl%0d_drop", i), 32'(bus.drop),      32'(tbl[i].drop));
      check($sformatf("tbl%0d_mis", i),  32'(bus.misroute),  32'(tbl[i].mis));
      check($sformatf("tbl%0d_stop", i), 32'(bus.stop),      32'(tbl[i].stop));
    end
    check_cnt("table");

    // Ordering with ack held: head visible the cycle after the first write.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'd0, 32'(i), 1'b1);
      if (i == 1) begin
        check("order_first_valid", 32'(bus.dout.valid), 32'h1);
        check("order_first_data",  bus.dout.data,       32'h1);
      end
      check("order_occ_peak", 32'(bus.occupancy <= 1), 32'h1);
    end
    drain();
    check_cnt("order");

    // Asynchronous reset mid-operation with the buffer holding entries and stop high.
    for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 32'h500 + 32'(i), 1'b0);
    bus.din = '0;
    bus.ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.dout.valid), 32'h0);
    check("async_rst_occ",   32'(bus.occupancy),  32'h0);
    check("async_rst_stop",  32'(bus.stop),       32'h0);
    model_reset();
    check_cnt("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 2'd0, 32'h0, 1'b1);

    // Streaming write+ack: pointers wrap many times without loss.
    for (int i = 0; i < 1000; i++) step(1'b1, 2'd0, $urandom, 1'b1);
    drain();
    check_cnt("wrap");

    // Saturation of the accept counter.
    for (int i = 0; i < 65536; i++) step(1'b1, 2'd0, 32'(i), 1'b1);
    drain();
    check_cnt("sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
